// File: rtl/jt10_adpcma_rom.sv
// ADPCM-A sample ROM responder: per-channel one-byte cache in front of a
// req/ack byte memory, with late-fetch detection and a one-deep request queue.
module jt10_adpcma_rom #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen6,
    input  logic          slot_sync,
    input  logic [19:0]   addr,
    input  logic [3:0]    bank,
    input  logic          roe_n,
    output logic [7:0]    datain,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ok,
    input  logic [7:0]    mem_data,
    input  logic          flush,
    output logic          late,
    input  logic          clr_late
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state, state_nxt;
    logic [2:0]  slot_cnt, cur_slot;
    logic [23:0] key, pend_key, q_key;
    logic [2:0]  pend_slot, q_slot;
    logic        q_valid, timely, nocache;
    logic [5:0]  c_valid;
    logic [23:0] c_key  [0:5];
    logic [7:0]  c_data [0:5];

    logic        ok_evt, fill_en, lookup, bypass, hit, miss, late_evt;
    logic        issue_new, issue_q;
    logic [7:0]  hit_data;

    assign key      = {bank, addr};
    assign cur_slot = slot_sync ? 3'd0 : slot_cnt;
    assign ok_evt   = (state == REQ) && mem_ok;
    assign fill_en  = ok_evt && !nocache && !flush;
    assign lookup   = cen6 && !roe_n;
    // A fill landing on the same cycle as the lookup is visible to it
    assign bypass   = fill_en && (pend_slot == cur_slot) && (pend_key == key);
    assign hit      = lookup && (bypass ||
                      (!flush && c_valid[cur_slot] && (c_key[cur_slot] == key)));
    assign hit_data = bypass ? mem_data : c_data[cur_slot];
    assign miss     = lookup && !hit;
    assign late_evt = cen6 && (state == REQ) && !mem_ok;

    assign mem_req  = (state == REQ);
    assign mem_addr = AW'(pend_key);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue_new = 1'b0;
        issue_q   = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    state_nxt = REQ;
                    issue_new = 1'b1;
                end else if (q_valid) begin
                    state_nxt = REQ;
                    issue_q   = 1'b1;
                end
            end
            REQ: if (mem_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= 3'd0;
            pend_key  <= 24'd0;
            pend_slot <= 3'd0;
            timely    <= 1'b0;
            nocache   <= 1'b0;
            q_valid   <= 1'b0;
            q_key     <= 24'd0;
            q_slot    <= 3'd0;
        end else begin
            if (cen6) slot_cnt <= (cur_slot == 3'd5) ? 3'd0 : cur_slot + 3'd1;

            if (issue_new) begin
                pend_key  <= key;
                pend_slot <= cur_slot;
                timely    <= 1'b1;
                nocache   <= flush;
            end else if (issue_q) begin
                pend_key  <= q_key;
                pend_slot <= q_slot;
                timely    <= 1'b1;
                nocache   <= flush;
            end else begin
                if (flush)    nocache <= 1'b1;
                if (late_evt) timely  <= 1'b0;
            end

            // Newest miss overwrites whatever is queued
            if (miss && state == REQ) begin
                q_valid <= 1'b1;
                q_key   <= key;
                q_slot  <= cur_slot;
            end else if (issue_new || issue_q) begin
                q_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 6'd0;
            for (int i = 0; i < 6; i++) begin
                c_key[i]  <= 24'd0;
                c_data[i] <= 8'd0;
            end
        end else begin
            if (flush) c_valid <= 6'd0;
            if (fill_en) begin
                c_valid[pend_slot] <= 1'b1;
                c_key[pend_slot]   <= pend_key;
                c_data[pend_slot]  <= mem_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            datain <= 8'd0;
            late   <= 1'b0;
        end else begin
            if (hit)                   datain <= hit_data;
            else if (ok_evt && timely) datain <= mem_data;

            if (late_evt)      late <= 1'b1;
            else if (clr_late) late <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jt10_adpcma_rom.sv
// Directed bench for jt10_adpcma_rom; memory acknowledges are driven by hand.
module tb_jt10_adpcma_rom;

    logic        clk = 1'b0;
    logic        rst_n, cen6, slot_sync, roe_n, mem_ok, flush, clr_late;
    logic [19:0] addr;
    logic [3:0]  bank;
    logic [7:0]  datain, mem_data;
    logic [23:0] mem_addr;
    logic        mem_req, late;

    int n_vec = 0;
    int n_err = 0;

    jt10_adpcma_rom #(.AW(24)) dut (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .slot_sync(slot_sync),
        .addr(addr), .bank(bank), .roe_n(roe_n), .datain(datain),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ok(mem_ok),
        .mem_data(mem_data), .flush(flush), .late(late), .clr_late(clr_late)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cen(input logic sync, input logic roe, input logic [19:0] a, input logic [3:0] b);
        cen6 = 1'b1; slot_sync = sync; roe_n = roe; addr = a; bank = b;
        tick();
        cen6 = 1'b0; slot_sync = 1'b0; roe_n = 1'b1;
    endtask

    task automatic idle_slot();
        do_cen(1'b0, 1'b1, 20'h0, 4'h0);
        tick();
        tick();
    endtask

    task automatic ack(input logic [7:0] d);
        mem_ok = 1'b1; mem_data = d;
        tick();
        mem_ok = 1'b0; mem_data = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; cen6 = 1'b0; slot_sync = 1'b0; roe_n = 1'b1; mem_ok = 1'b0;
        flush = 1'b0; clr_late = 1'b0; addr = '0; bank = '0; mem_data = '0;
        repeat (3) tick();
        check("rst_datain", datain, 8'h00);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 24'h0);
        check("rst_late", late, 1'b0);
        rst_n = 1'b1;
        tick();

        // slot 0 cold miss
        do_cen(1'b0, 1'b0, 20'h00010, 4'h1);
        check("miss0_req", mem_req, 1'b1);
        check("miss0_addr", mem_addr, 24'h100010);
        tick(); tick();
        ack(8'hA5);
        check("miss0_datain", datain, 8'hA5);
        check("miss0_req_fall", mem_req, 1'b0);
        check("miss0_late", late, 1'b0);
        repeat (5) idle_slot();

        // slot 0 second round hits
        do_cen(1'b0, 1'b0, 20'h00010, 4'h1);
        check("hit0_datain", datain, 8'hA5);
        check("hit0_no_req", mem_req, 1'b0);
        tick();
        check("hit0_no_req2", mem_req, 1'b0);
        idle_slot();

        // slot 2 miss served late; slot 3 miss queued behind it
        do_cen(1'b0, 1'b0, 20'h00200, 4'h2);
        check("miss2_req", mem_req, 1'b1);
        check("miss2_addr", mem_addr, 24'h200200);
        tick(); tick();
        do_cen(1'b0, 1'b0, 20'h00300, 4'h3);
        check("late_set", late, 1'b1);
        check("late_req_held", mem_req, 1'b1);
        check("late_addr_stable", mem_addr, 24'h200200);
        check("late_datain_hold", datain, 8'hA5);
        ack(8'h3C);
        check("late_byte_not_driven", datain, 8'hA5);
        check("late_req_fall", mem_req, 1'b0);
        tick();
        check("queue_req", mem_req, 1'b1);
        check("queue_addr", mem_addr, 24'h300300);
        ack(8'h4B);
        check("queue_req_fall", mem_req, 1'b0);
        clr_late = 1'b1;
        tick();
        clr_late = 1'b0;
        check("late_clr", late, 1'b0);
        repeat (4) idle_slot();
        do_cen(1'b0, 1'b0, 20'h00200, 4'h2);
        check("hit2_datain", datain, 8'h3C);
        check("hit2_no_req", mem_req, 1'b0);
        tick();

        // mem_ok coincident with cen6 (slot_sync returns to slot 0)
        do_cen(1'b1, 1'b0, 20'h00444, 4'h4);
        check("co_req", mem_req, 1'b1);
        check("co_addr", mem_addr, 24'h400444);
        tick();
        cen6 = 1'b1; slot_sync = 1'b1; roe_n = 1'b0; addr = 20'h00444; bank = 4'h4;
        mem_ok = 1'b1; mem_data = 8'h77;
        tick();
        cen6 = 1'b0; slot_sync = 1'b0; roe_n = 1'b1; mem_ok = 1'b0; mem_data = 8'h00;
        check("co_datain", datain, 8'h77);
        check("co_late", late, 1'b0);
        check("co_req_fall", mem_req, 1'b0);
        tick();
        check("co_no_refetch", mem_req, 1'b0);
        repeat (3) idle_slot();

        // flush with slot 4 in flight
        do_cen(1'b0, 1'b0, 20'h00555, 4'h5);
        check("fl_req", mem_req, 1'b1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ack(8'h99);
        check("fl_datain", datain, 8'h99);
        check("fl_req_fall", mem_req, 1'b0);
        repeat (5) idle_slot();
        do_cen(1'b0, 1'b0, 20'h00555, 4'h5);
        check("fl_refetch_req", mem_req, 1'b1);
        check("fl_refetch_addr", mem_addr, 24'h500555);
        ack(8'h99);

        // twelve slots with roe_n high
        for (int i = 0; i < 12; i++) begin
            idle_slot();
            check($sformatf("roe_hi_req%0d", i), mem_req, 1'b0);
        end
        check("roe_hi_datain", datain, 8'h99);
        check("roe_hi_late", late, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
